// File: rtl/sipo_block_assembler.sv
// Collects UART RX bytes into one wide block, first byte in the MSBs, and presents it with
// valid/ready. Stale partial blocks are dropped after an idle timeout; bytes lost while full are flagged.
module sipo_block_assembler #(
    parameter int unsigned BLOCK_BYTES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_in,
    input  logic                       block_ready,
    input  logic                       clr_overrun,
    output logic [8*BLOCK_BYTES-1:0]   parallel_out,
    output logic                       block_valid,
    output logic [4:0]                 byte_count,
    output logic                       overrun,
    output logic                       timeout
);

    localparam int unsigned DATA_W    = 8 * BLOCK_BYTES;
    localparam int unsigned HIST_W    = DATA_W - 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned LAST_BYTE = BLOCK_BYTES - 1;
    localparam int unsigned IDLE_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [HIST_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   parallel_out_q, parallel_out_d;
    logic                block_valid_q, block_valid_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [DATA_W-1:0]   shifted;

    // Only the previous BLOCK_BYTES-1 bytes need storing; the newest byte completes the block.
    assign shifted = {shift_q, byte_in};

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        parallel_out_d = parallel_out_q;
        block_valid_d  = block_valid_q;
        byte_count_d   = byte_count_q;
        overrun_d      = overrun_q;
        timeout_d      = 1'b0;
        idle_d         = idle_q;

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            S_COLLECT: begin
                if (byte_valid) begin
                    shift_d = shifted[HIST_W-1:0];
                    idle_d  = '0;
                    if (byte_count_q == CNT_W'(LAST_BYTE)) begin
                        parallel_out_d = shifted;
                        block_valid_d  = 1'b1;
                        byte_count_d   = '0;
                        state_d        = S_FULL;
                    end else begin
                        byte_count_d = byte_count_q + CNT_W'(1);
                    end
                end else if (TIMEOUT_CYCLES != 0 && byte_count_q != '0) begin
                    if (idle_q == IDLE_W'(TO_LAST)) begin
                        byte_count_d = '0;
                        shift_d      = '0;
                        timeout_d    = 1'b1;
                        idle_d       = '0;
                    end else if (idle_q != '1) begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (block_ready) begin
                    block_valid_d = 1'b0;
                    state_d       = S_COLLECT;
                    // A byte arriving with the handshake starts the next block.
                    if (byte_valid) begin
                        shift_d      = shifted[HIST_W-1:0];
                        byte_count_d = CNT_W'(1);
                        idle_d       = '0;
                    end
                end else if (byte_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_COLLECT;
            shift_q        <= '0;
            parallel_out_q <= '0;
            block_valid_q  <= 1'b0;
            byte_count_q   <= '0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
            idle_q         <= '0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            parallel_out_q <= parallel_out_d;
            block_valid_q  <= block_valid_d;
            byte_count_q   <= byte_count_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
            idle_q         <= idle_d;
        end
    end

    assign parallel_out = parallel_out_q;
    assign block_valid  = block_valid_q;
    assign byte_count   = byte_count_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_sipo_block_assembler.sv
// Directed bench for sipo_block_assembler with a block scoreboard and a cycle model of the outputs.
module tb_sipo_block_assembler;

    localparam int unsigned TO = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         block_ready = 1'b0;
    logic         clr_overrun = 1'b0;
    logic [127:0] parallel_out;
    logic         block_valid;
    logic [4:0]   byte_count;
    logic         overrun;
    logic         timeout;

    sipo_block_assembler #(
        .BLOCK_BYTES   (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .block_ready (block_ready),
        .clr_overrun (clr_overrun),
        .parallel_out(parallel_out),
        .block_valid (block_valid),
        .byte_count  (byte_count),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    logic [127:0] exp_q[$];
    logic [119:0] m_shift;
    logic [127:0] m_out;
    bit           m_full, m_ovr, m_to;
    int           m_cnt, m_idle;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_shift = '0; m_out = '0; m_full = 0; m_ovr = 0; m_to = 0; m_cnt = 0; m_idle = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pout"}, parallel_out, 128'h0);
        chk({tag, "_valid"}, 128'(block_valid), 128'h0);
        chk({tag, "_cnt"}, 128'(byte_count), 128'h0);
        chk({tag, "_ovr"}, 128'(overrun), 128'h0);
        chk({tag, "_to"}, 128'(timeout), 128'h0);
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model over the edge.
    task automatic step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
        bit was_full;
        bit acc;
        bit drop;
        logic [127:0] exp_blk;
        byte_valid = v; byte_in = b; block_ready = rdy; clr_overrun = clr;
        chk("m_valid", 128'(block_valid), 128'(m_full));
        chk("m_cnt", 128'(byte_count), 128'(m_cnt));
        chk("m_ovr", 128'(overrun), 128'(m_ovr));
        chk("m_to", 128'(timeout), 128'(m_to));
        chk("m_pout", parallel_out, m_out);
        was_full = m_full;
        acc  = v && (!m_full || rdy);
        drop = v && m_full && !rdy;
        m_to = 0;
        if (m_full && rdy) begin
            if (exp_q.size() == 0) begin
                chk("hs_queue_empty", 128'(1), 128'(0));
            end else begin
                exp_blk = exp_q.pop_front();
                chk("hs_block", parallel_out, exp_blk);
            end
            hs_cnt++;
            m_full = 0;
        end
        if (acc) begin
            m_idle = 0;
            if (m_cnt == 15) begin
                m_out = {m_shift, b};
                exp_q.push_back(m_out);
                m_full = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_shift = {m_shift[111:0], b};
        end else if (!was_full && m_cnt > 0) begin
            if (m_idle == int'(TO) - 1) begin
                m_cnt = 0; m_shift = '0; m_to = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
        tick();
        byte_valid = 1'b0; block_ready = 1'b0; clr_overrun = 1'b0;
    endtask

    initial begin
        model_clear();
        do_reset();
        chk_reset_state("reset");

        // 1: sixteen bytes 00..0F form one block
        for (int i = 0; i < 15; i++) step(1, 8'(i), 0, 0);
        chk("t1_not_yet_valid", 128'(block_valid), 128'h0);
        chk("t1_cnt15", 128'(byte_count), 128'd15);
        step(1, 8'h0F, 0, 0);
        chk("t1_valid", 128'(block_valid), 128'h1);
        chk("t1_cnt0", 128'(byte_count), 128'h0);
        chk("t1_block", parallel_out, 128'h000102030405060708090A0B0C0D0E0F);

        // 2: bytes while full are dropped and flag overrun
        for (int i = 0; i < 3; i++) step(1, 8'hF0 + 8'(i), 0, 0);
        chk("t2_hold", parallel_out, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t2_ovr", 128'(overrun), 128'h1);
        step(0, 8'h00, 0, 1);
        chk("t2_clr", 128'(overrun), 128'h0);
        step(1, 8'h55, 0, 1);
        chk("t2_set_wins", 128'(overrun), 128'h1);
        step(0, 8'h00, 0, 1);

        // 3: handshake and new byte in the same cycle
        step(1, 8'hAA, 1, 0);
        chk("t3_valid0", 128'(block_valid), 128'h0);
        chk("t3_cnt1", 128'(byte_count), 128'h1);
        chk("t3_ovr0", 128'(overrun), 128'h0);
        for (int i = 0; i < 15; i++) step(1, 8'($urandom_range(0, 255)), 0, 0);
        chk("t3_valid", 128'(block_valid), 128'h1);
        chk("t3_msb", 128'(parallel_out[127:120]), 128'hAA);
        step(0, 8'h00, 1, 0);

        // 4: idle timeout discards a partial block; a byte on the last idle cycle wins
        for (int i = 0; i < 5; i++) step(1, 8'h30 + 8'(i), 0, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 0);
        chk("t4_before_to", 128'(timeout), 128'h0);
        chk("t4_cnt5", 128'(byte_count), 128'd5);
        step(0, 8'h00, 0, 0);
        chk("t4_to_pulse", 128'(timeout), 128'h1);
        chk("t4_cnt0", 128'(byte_count), 128'h0);
        step(0, 8'h00, 0, 0);
        chk("t4_to_once", 128'(timeout), 128'h0);
        for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 0, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 0);
        step(1, 8'h45, 0, 0);
        chk("t4_byte_wins_to", 128'(timeout), 128'h0);
        chk("t4_byte_wins_cnt", 128'(byte_count), 128'd6);
        for (int i = 6; i < 16; i++) step(1, 8'h40 + 8'(i), 0, 0);
        chk("t4_clean_block", parallel_out, 128'h404142434445464748494A4B4C4D4E4F);
        step(0, 8'h00, 1, 0);

        // 5: reset mid-block and while full
        for (int i = 0; i < 7; i++) step(1, 8'h70 + 8'(i), 0, 0);
        do_reset();
        chk_reset_state("t5_mid");
        for (int i = 0; i < 16; i++) step(1, 8'h80 + 8'(i), 0, 0);
        step(1, 8'hEE, 0, 0);
        chk("t5_ovr_before", 128'(overrun), 128'h1);
        do_reset();
        chk_reset_state("t5_full");

        // 6: 32 back-to-back bytes with the consumer always ready
        hs_cnt = 0;
        for (int i = 0; i < 32; i++) step(1, 8'(i * 7 + 3), 1, 0);
        for (int k = 0; k < 8 && hs_cnt < 2; k++) step(0, 8'h00, 1, 0);
        chk("t6_two_blocks", 128'(hs_cnt), 128'd2);
        chk("t6_no_ovr", 128'(overrun), 128'h0);
        chk("t6_queue_drained", 128'(exp_q.size()), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
